// File: rtl/mem_a_pkg.sv
// Shared constants and types for the skewed row memory (mem_a) and its companions.
package mem_a_pkg;

  localparam int unsigned BITS_AB_DEF = 8;
  localparam int unsigned DIM_DEF     = 8;

  typedef logic signed [BITS_AB_DEF-1:0] elem_t;

  // Per-row operation selected each cycle; load takes priority over shift.
  typedef enum logic [1:0] {
    ROW_HOLD  = 2'd0,
    ROW_SHIFT = 2'd1,
    ROW_LOAD  = 2'd2
  } row_op_e;

endpackage

// File: rtl/mem_a_if.sv
// Bundle of the row-write / shift bus feeding mem_a and the skewed lane outputs.
interface mem_a_if
  import mem_a_pkg::*;
#(
  parameter int unsigned BITS_AB = BITS_AB_DEF,
  parameter int unsigned DIM     = DIM_DEF
);
  logic                        en;
  logic                        WrEn;
  logic signed [BITS_AB-1:0]   Ain  [DIM-1:0];
  logic [$clog2(DIM)-1:0]      Arow;
  logic signed [BITS_AB-1:0]   Aout [DIM-1:0];

  modport master (output en, WrEn, Ain, Arow, input  Aout);
  modport slave  (input  en, WrEn, Ain, Arow, output Aout);
endinterface

// File: rtl/mem_a_row.sv
// One skewed shift row: ROW leading zeros, DIM data entries, head at index 0.
module mem_a_row
  import mem_a_pkg::*;
#(
  parameter int unsigned BITS_AB = BITS_AB_DEF,
  parameter int unsigned DIM     = DIM_DEF,
  parameter int unsigned ROW     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  row_op_e                   op,
  input  logic signed [BITS_AB-1:0] din  [DIM-1:0],
  output logic signed [BITS_AB-1:0] head
);

  localparam int unsigned DEPTH = DIM + ROW;

  logic signed [BITS_AB-1:0] ent_q [DEPTH];
  logic signed [BITS_AB-1:0] ent_d [DEPTH];

  always_comb begin
    ent_d = ent_q;
    unique case (op)
      ROW_LOAD: begin
        ent_d = '{default: '0};
        for (int unsigned j = 0; j < DIM; j++) begin
          ent_d[ROW + j] = din[j];
        end
      end
      ROW_SHIFT: begin
        for (int unsigned k = 0; k < DEPTH - 1; k++) begin
          ent_d[k] = ent_q[k + 1];
        end
        ent_d[DEPTH - 1] = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '{default: '0};
    end else begin
      ent_q <= ent_d;
    end
  end

  assign head = ent_q[0];

endmodule

// File: rtl/mem_a.sv
// Skewed operand memory: DIM rows of increasing depth, each presenting its head element on Aout.
module mem_a
  import mem_a_pkg::*;
#(
  parameter int unsigned BITS_AB = BITS_AB_DEF,
  parameter int unsigned DIM     = DIM_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic signed [BITS_AB-1:0] Ain  [DIM-1:0],
  input  logic [$clog2(DIM)-1:0]    Arow,
  output logic signed [BITS_AB-1:0] Aout [DIM-1:0]
);

  for (genvar i = 0; i < DIM; i++) begin : g_row
    logic    wr;
    row_op_e op;

    // Out-of-range Arow (non power-of-two DIM) matches no row and is dropped.
    always_comb begin
      wr = WrEn && (32'(Arow) == 32'(i));
      op = ROW_HOLD;
      if (wr) begin
        op = ROW_LOAD;
      end else if (en) begin
        op = ROW_SHIFT;
      end
    end

    mem_a_row #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM),
      .ROW     (i)
    ) u_row (
      .clk  (clk),
      .rst  (rst_n),
      .op   (op),
      .din  (Ain),
      .head (Aout[i])
    );
  end

endmodule

// File: tb/tb_mem_a.sv
// Directed + randomized check of mem_a against a skew-formula reference model.
module tb_mem_a;
  import mem_a_pkg::*;

  localparam int unsigned DIM  = 8;
  localparam int unsigned BITS = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_a_if #(.BITS_AB(BITS), .DIM(DIM)) bus ();

  mem_a #(.BITS_AB(BITS), .DIM(DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .WrEn  (bus.WrEn),
    .Ain   (bus.Ain),
    .Arow  (bus.Arow),
    .Aout  (bus.Aout)
  );

  // Model: each row remembers its loaded vector and how many shifts since the load.
  logic signed [BITS-1:0] m_data [DIM][DIM];
  int                     m_k    [DIM];
  bit                     m_v    [DIM];

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic signed [BITS-1:0] exp_lane(int i);
    int k;
    k = m_k[i];
    if (!m_v[i]) return '0;
    if (k < i || k >= i + int'(DIM)) return '0;
    return m_data[i][k - i];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < int'(DIM); i++) begin
      m_v[i] = 1'b0;
      m_k[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_clear();
    end else begin
      for (int i = 0; i < int'(DIM); i++) begin
        if (bus.WrEn && int'(bus.Arow) == i) begin
          for (int j = 0; j < int'(DIM); j++) m_data[i][j] = bus.Ain[j];
          m_k[i] = 0;
          m_v[i] = 1'b1;
        end else if (bus.en && m_k[i] < 1000) begin
          m_k[i] = m_k[i] + 1;
        end
      end
    end
    #1;
  endtask

  task automatic check_all(string tag);
    logic signed [BITS-1:0] e;
    for (int i = 0; i < int'(DIM); i++) begin
      e = exp_lane(i);
      n_assert++;
      assert (bus.Aout[i] === e) else begin
        n_fail++;
        $error("FAIL %s lane %0d: got %0d expected %0d", tag, i, bus.Aout[i], e);
      end
    end
  endtask

  task automatic check_lane(string tag, int i, logic signed [BITS-1:0] e);
    n_assert++;
    assert (bus.Aout[i] === e) else begin
      n_fail++;
      $error("FAIL %s lane %0d: got %0d expected %0d", tag, i, bus.Aout[i], e);
    end
  endtask

  task automatic idle();
    bus.WrEn = 1'b0;
    bus.en   = 1'b0;
    bus.Arow = '0;
    for (int j = 0; j < int'(DIM); j++) bus.Ain[j] = '0;
  endtask

  task automatic load_a();
    for (int i = 0; i < int'(DIM); i++) begin
      for (int j = 0; j < int'(DIM); j++) bus.Ain[j] = 8'(i * 8 + j - 32);
      bus.WrEn = 1'b1;
      bus.en   = 1'b0;
      bus.Arow = 3'(i);
      tick();
      check_all("load");
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    model_clear();
    #2;
    check_all("reset_async");
    tick();
    check_all("reset_edge");
    rst_n = 1'b0;
    tick();
    check_all("post_reset");

    // Load then drain, with hold in between.
    load_a();
    check_lane("k0_lane0", 0, -8'sd32);
    for (int c = 0; c < 5; c++) begin
      tick();
      check_all("hold");
    end
    check_lane("hold_lane0", 0, -8'sd32);
    check_lane("hold_lane1", 1, 8'sd0);
    bus.en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      check_all("drain");
      if (k == 7) begin
        check_lane("k7_lane0", 0, -8'sd25);
        check_lane("k7_lane7", 7, 8'sd24);
      end
      if (k == 14) begin
        check_lane("k14_lane7", 7, 8'sd31);
        check_lane("k14_lane6", 6, 8'sd0);
      end
      tick();
    end
    check_all("drained");
    idle();

    // Write row 2 during shift at k=3.
    load_a();
    bus.en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check_all("wr_shift");
      if (k == 3) begin
        bus.WrEn = 1'b1;
        bus.Arow = 3'd2;
        for (int j = 0; j < int'(DIM); j++) bus.Ain[j] = 8'sd5;
      end else begin
        bus.WrEn = 1'b0;
      end
      if (k == 4 || k == 5) check_lane("rewr_zero", 2, 8'sd0);
      if (k == 6) check_lane("rewr_five", 2, 8'sd5);
      tick();
    end
    idle();

    // Asynchronous reset in the middle of a drain.
    load_a();
    bus.en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_all("pre_rst");
      tick();
    end
    check_all("pre_rst_k4");
    #2;
    rst_n = 1'b1;
    model_clear();
    #1;
    check_all("mid_rst_async");
    bus.WrEn = 1'b1;
    bus.Arow = 3'd0;
    for (int j = 0; j < int'(DIM); j++) bus.Ain[j] = 8'sd7;
    tick();
    check_all("rst_override");
    rst_n = 1'b0;
    idle();
    bus.en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_all("after_rst");
    end
    idle();

    // Partial load of row 5 only.
    for (int j = 0; j < int'(DIM); j++) bus.Ain[j] = 8'(j + 1);
    bus.WrEn = 1'b1;
    bus.Arow = 3'd5;
    tick();
    idle();
    bus.en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check_all("partial");
      if (k == 4)  check_lane("partial_k4", 5, 8'sd0);
      if (k == 5)  check_lane("partial_k5", 5, 8'sd1);
      if (k == 12) check_lane("partial_k12", 5, 8'sd8);
      if (k == 13) check_lane("partial_k13", 5, 8'sd0);
      tick();
    end
    idle();

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 400; c++) begin
      bus.WrEn = ($urandom_range(0, 3) == 0);
      bus.en   = ($urandom_range(0, 3) != 0);
      bus.Arow = 3'($urandom_range(0, int'(DIM) - 1));
      for (int j = 0; j < int'(DIM); j++) bus.Ain[j] = 8'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        #2;
        rst_n = 1'b1;
        model_clear();
        #1;
        check_all("rand_rst");
        tick();
        rst_n = 1'b0;
      end else begin
        tick();
      end
      check_all("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
